spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 8-bit registers (legal range 1..256).
REQ-002 Parameter ID_VALUE, default 8'hAD, read-only contents of register 0x00.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk, cs and mosi (minimum 2).
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 cs  input  1  SPI chip select, active low, asynchronous.
REQ-008 mosi  input  1  SPI serial data in, MSB first.
REQ-009 miso  output  1  SPI serial data out, MSB first.
REQ-010 miso_oe  output  1  high while a read is driving miso; the top level builds the tristate from miso_oe.
REQ-011 wr_strobe  output  1  one-clk pulse per completed SPI data-byte write.
REQ-012 wr_addr  output  8  register address of the current wr_strobe.
REQ-013 wr_data  output  8  data byte of the current wr_strobe.
REQ-014 dbg_addr  input  8  local read address (combinational port).
REQ-015 dbg_rdata  output  8  register contents at dbg_addr; 8'h00 if out of range.

Function
REQ-016 sclk, cs and mosi shall each pass through SYNC_STAGES flops; all edge detection uses the synchronized values.
REQ-017 sclk rise and fall events shall be one-clk pulses from synchronized current/previous compare; operation requires an sclk period of at least 8 clk periods.
REQ-018 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-019 IDLE->CMD on synchronized cs falling; in every state, synchronized cs high forces IDLE next clk.
REQ-020 The bit counter (0..7) shall clear on cs falling and wrap after each 8th sclk rise; a byte completes on the 8th rise.
REQ-021 CMD byte: 8'h0A -> ADDR(write), 8'h0B -> ADDR(read), any other value -> IGNORE until cs high.
REQ-022 ADDR byte: latch into the 8-bit address pointer, then go to WDATA or RDATA.
REQ-023 WDATA: each completed byte shall assert wr_strobe for exactly one clk in the cycle after completion, with wr_addr = pointer and wr_data = byte.
REQ-024 WDATA: the register write is performed only if pointer < NUM_REGS and pointer != 0; otherwise no register changes, but wr_strobe still pulses.
REQ-025 RDATA: on ADDR completion and on each data-byte completion, load the tx shift register with reg[pointer] (8'h00 if out of range; ID_VALUE at 0x00).
REQ-026 miso = tx[7]; tx shall shift left on each sclk fall in RDATA except the fall that follows a load.
REQ-027 miso_oe = 1 in RDATA only; 0 otherwise, with miso = 0.
REQ-028 After each completed data byte (read or write), the pointer shall increment; from NUM_REGS-1 it wraps to 0x00.
REQ-029 If cs rises mid-byte, the partial byte shall be discarded: no wr_strobe and no pointer change.
REQ-030 sclk events while synchronized cs is high shall be ignored.

Reset
REQ-031 rst shall put the FSM in IDLE, clear the bit counter, pointer and tx, and set wr_strobe=0, wr_addr=0, wr_data=0, miso=0 and miso_oe=0.
REQ-032 rst shall load registers 1..NUM_REGS-1 with 8'h00; register 0 is always ID_VALUE.
REQ-033 rst asserted mid-transaction shall abort it; the block then waits for a fresh cs falling edge, even if cs is already low.

Verification
REQ-034 Write 0x0A,0x05,0x3C -> wr_strobe pulses once with addr 0x05 and data 0x3C; dbg_addr=0x05 then reads 0x3C.
REQ-035 Read 0x0B,0x00 plus one data byte -> master samples 0xAD; miso_oe=1 only during the data byte.
REQ-036 Burst write 0x0A,0x0E,0x11,0x22,0x33 with NUM_REGS=16 -> reg14=0x11, reg15=0x22, and the write to reg0 is ignored (strobe addr 0x00); a burst read from 0x0E returns 0x11,0x22,0xAD.
REQ-037 Command 0x0C followed by 16 bits -> no wr_strobe, miso_oe stays 0, registers unchanged.
REQ-038 Write 0x0A,0x03 then 4 bits of data, then cs high -> no wr_strobe and reg3 unchanged; the next full transaction works normally.
REQ-039 rst pulsed mid-read with cs held low -> all outputs reach their reset values; no response until cs toggles high then low.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small byte-wide register file; register 0 is a read-only ID.
// All SPI pins are resynchronized into clk; sclk must be at least 8 clk periods long.
module spi_slave_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter logic [7:0]  ID_VALUE    = 8'hAD,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_rdata
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   skip_q, skip_d;
    logic                   rd_q, rd_d;
    logic [7:0]             ptr_q, ptr_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [7:0]             wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall;
    logic       byte_done;
    logic [7:0] byte_val;
    logic [7:0] ptr_inc;
    logic       ptr_writable;

    // Entry 0 holds ID_VALUE permanently, so one lookup serves every address.
    function automatic logic [7:0] reg_read(input logic [NUM_REGS-1:0][7:0] r,
                                            input logic [7:0] a);
        reg_read = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == 8'(i)) reg_read = r[i];
        end
    endfunction

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_fall   = cs_prev_q & ~cs_s;

    assign byte_val     = {rx_q[6:0], mosi_s};
    assign byte_done    = (state_q != IDLE) && sclk_rise && (bit_cnt_q == 3'd7);
    assign ptr_inc      = (ptr_q == 8'(NUM_REGS - 1)) ? 8'h00 : ptr_q + 8'd1;
    assign ptr_writable = (ptr_q != 8'h00) && ({1'b0, ptr_q} < 9'(NUM_REGS));

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        skip_d      = skip_q;
        rd_d        = rd_q;
        ptr_d       = ptr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;
        regs_d[0]   = ID_VALUE;

        if (cs_fall) begin
            bit_cnt_d = 3'd0;
        end else if ((state_q != IDLE) && sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = byte_val;
        end

        if (cs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: if (byte_done) begin
                    if (byte_val == CMD_WRITE) begin
                        state_d = ADDR;
                        rd_d    = 1'b0;
                    end else if (byte_val == CMD_READ) begin
                        state_d = ADDR;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ADDR: if (byte_done) begin
                    ptr_d = byte_val;
                    if (rd_q) begin
                        state_d = RDATA;
                        tx_d    = reg_read(regs_q, byte_val);
                        skip_d  = 1'b1;
                    end else begin
                        state_d = WDATA;
                    end
                end
                WDATA: if (byte_done) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = byte_val;
                    for (int i = 1; i < NUM_REGS; i++) begin
                        if (ptr_writable && ptr_q == 8'(i)) regs_d[i] = byte_val;
                    end
                    ptr_d = ptr_inc;
                end
                RDATA: begin
                    // The fall right after a load must keep the new MSB on miso.
                    if (byte_done) begin
                        ptr_d  = ptr_inc;
                        tx_d   = reg_read(regs_q, ptr_inc);
                        skip_d = 1'b1;
                    end else if (sclk_fall) begin
                        if (skip_q) skip_d = 1'b0;
                        else        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // cs chain resets low so a cs already held low does not look like a new falling edge.
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            skip_q      <= 1'b0;
            rd_q        <= 1'b0;
            ptr_q       <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            skip_q      <= skip_d;
            rd_q        <= rd_d;
            ptr_q       <= ptr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign miso_oe   = (state_q == RDATA);
    assign miso      = miso_oe & tx_q[7];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign dbg_rdata = reg_read(regs_q, dbg_addr);

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed scenarios plus random transactions against a register-array model.
module tb_spi_slave_regfile;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, wr_strobe;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0]  bq[$];
    logic [7:0]  rxq[$];
    logic [1:0]  oeq[$];
    logic [15:0] sb[$];
    logic [15:0] exp_sb[$];
    logic [7:0]  exp_rx[$];
    logic [1:0]  exp_oe[$];
    logic [7:0]  mem [16];

    spi_slave_regfile dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Every clk with wr_strobe high is recorded; a stretched pulse shows up as an extra entry.
    always @(negedge clk) if (wr_strobe) sb.push_back({wr_addr, wr_data});

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [7:0] a);
        if (a == 8'h00)      return 8'hAD;
        else if (a < 8'd16)  return mem[a[3:0]];
        else                 return 8'h00;
    endfunction

    // Master side: mosi set while sclk low, miso sampled just before the rising edge.
    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r, output logic [1:0] oe);
        logic all1, any1;
        all1 = 1'b1; any1 = 1'b0; r = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wclk(HALF);
            r = {r[6:0], miso};
            all1 &= miso_oe;
            any1 |= miso_oe;
            sclk = 1'b1;
            wclk(HALF);
            sclk = 1'b0;
        end
        oe = {all1, any1};
    endtask

    task automatic send_bytes();
        logic [7:0] r;
        logic [1:0] o;
        rxq.delete(); oeq.delete();
        foreach (bq[i]) begin
            spi_bits(bq[i], 8, r, o);
            rxq.push_back(r);
            oeq.push_back(o);
        end
    endtask

    task automatic run_xact();
        sb.delete();
        cs = 1'b0; wclk(4);
        send_bytes();
        wclk(HALF); cs = 1'b1; wclk(8);
    endtask

    task automatic model_xact();
        logic [7:0] p;
        exp_sb.delete(); exp_rx.delete(); exp_oe.delete();
        foreach (bq[i]) begin
            exp_rx.push_back(8'h00);
            exp_oe.push_back(2'b00);
        end
        if (bq.size() >= 2 && (bq[0] == 8'h0A || bq[0] == 8'h0B)) begin
            p = bq[1];
            for (int k = 2; k < bq.size(); k++) begin
                if (bq[0] == 8'h0A) begin
                    exp_sb.push_back({p, bq[k]});
                    if (p != 8'h00 && p < 8'd16) mem[p[3:0]] = bq[k];
                end else begin
                    exp_rx[k] = ref_rd(p);
                    exp_oe[k] = 2'b11;
                end
                p = (p == 8'd15) ? 8'd0 : p + 8'd1;
            end
        end
    endtask

    task automatic scan_regs();
        for (int a = 0; a < 18; a++) begin
            dbg_addr = 8'(a); #1;
            chk($sformatf("dbg_reg%0d", a), {8'h00, dbg_rdata}, {8'h00, ref_rd(8'(a))});
        end
        dbg_addr = 8'hFF; #1;
        chk("dbg_reg255", {8'h00, dbg_rdata}, 16'h0000);
    endtask

    task automatic check_xact(input string tag);
        chk({tag, "_nstrobe"}, 16'(sb.size()), 16'(exp_sb.size()));
        for (int i = 0; i < sb.size() && i < exp_sb.size(); i++)
            chk({tag, "_strobe"}, sb[i], exp_sb[i]);
        foreach (exp_oe[k]) begin
            chk({tag, "_oe"}, {14'h0, oeq[k]}, {14'h0, exp_oe[k]});
            if (exp_oe[k] == 2'b11) chk({tag, "_rdata"}, {8'h00, rxq[k]}, {8'h00, exp_rx[k]});
        end
        chk({tag, "_idle_oe"}, {15'h0, miso_oe}, 16'h0000);
        chk({tag, "_idle_miso"}, {15'h0, miso}, 16'h0000);
        scan_regs();
    endtask

    task automatic do_xact(input string tag);
        model_xact();
        run_xact();
        check_xact(tag);
    endtask

    initial begin
        logic [7:0] r, c;
        logic [1:0] o;
        int sel, nd;

        dbg_addr = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        wclk(5);
        rst = 1'b0;
        wclk(1);
        chk("rst_strobe", {15'h0, wr_strobe}, 16'h0000);
        chk("rst_addr", {8'h00, wr_addr}, 16'h0000);
        chk("rst_data", {8'h00, wr_data}, 16'h0000);
        chk("rst_miso", {15'h0, miso}, 16'h0000);
        chk("rst_oe", {15'h0, miso_oe}, 16'h0000);
        scan_regs();
        wclk(8);

        bq = {8'h0A, 8'h05, 8'h3C};
        do_xact("write1");
        dbg_addr = 8'h05; #1;
        chk("write1_reg5", {8'h00, dbg_rdata}, 16'h003C);

        bq = {8'h0B, 8'h00, 8'hFF};
        do_xact("read_id");
        chk("read_id_val", {8'h00, rxq[2]}, 16'h00AD);

        bq = {8'h0A, 8'h0E, 8'h11, 8'h22, 8'h33};
        do_xact("burst_wr");
        chk("burst_wr_last", sb.size() == 3 ? sb[2] : 16'hFFFF, 16'h0033);
        bq = {8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00};
        do_xact("burst_rd");
        chk("burst_rd_wrap", {8'h00, rxq[4]}, 16'h00AD);

        bq = {8'h0C, 8'h5A, 8'hA5};
        do_xact("bad_cmd");

        // Aborted write: cs rises after four data bits.
        sb.delete();
        cs = 1'b0; wclk(4);
        spi_bits(8'h0A, 8, r, o);
        spi_bits(8'h03, 8, r, o);
        spi_bits(8'hFF, 4, r, o);
        wclk(HALF); cs = 1'b1; wclk(8);
        chk("partial_nstrobe", 16'(sb.size()), 16'h0000);
        scan_regs();
        bq = {8'h0A, 8'h03, 8'h99};
        do_xact("after_partial");

        // Reset in the middle of a read data byte while cs stays low.
        sb.delete();
        cs = 1'b0; wclk(4);
        spi_bits(8'h0B, 8, r, o);
        spi_bits(8'h00, 8, r, o);
        spi_bits(8'hFF, 3, r, o);
        chk("midrd_oe", {15'h0, miso_oe}, 16'h0001);
        rst = 1'b1; wclk(2); rst = 1'b0; wclk(1);
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        chk("midrst_strobe", {15'h0, wr_strobe}, 16'h0000);
        chk("midrst_addr", {8'h00, wr_addr}, 16'h0000);
        chk("midrst_data", {8'h00, wr_data}, 16'h0000);
        chk("midrst_miso", {15'h0, miso}, 16'h0000);
        chk("midrst_oe", {15'h0, miso_oe}, 16'h0000);
        sb.delete();
        bq = {8'h0A, 8'h05, 8'h77};
        send_bytes();
        foreach (oeq[k]) chk("postrst_oe", {14'h0, oeq[k]}, 16'h0000);
        wclk(HALF); cs = 1'b1; wclk(8);
        chk("postrst_nstrobe", 16'(sb.size()), 16'h0000);
        scan_regs();
        bq = {8'h0A, 8'h05, 8'h3C};
        do_xact("postrst_write");

        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 3);
            c = (sel == 1) ? 8'h0B : 8'h0A;
            if (sel == 3) begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h0A || c == 8'h0B) c = 8'h0C;
            end
            nd = $urandom_range(1, 4);
            bq = {c, 8'($urandom_range(0, 17))};
            for (int k = 0; k < nd; k++) bq.push_back(8'($urandom));
            do_xact($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
